// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared read-FSM encoding and CTRL bit positions for gpio_in_ext
package gpio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rd_state_t;

    localparam int CTRL_BLOCK        = 0;
    localparam int CTRL_IRQ_EN       = 1;
    localparam int CTRL_TIMEOUT_FLAG = 7;

endpackage

// File: rtl/gpio_prio_enc.sv
// rtl/gpio_prio_enc.sv - lowest-numbered pending channel encoder
module gpio_prio_enc #(
    parameter int CHANNELS = 4
) (
    input  logic [CHANNELS-1:0] pending,
    output logic [5:0]          index,
    output logic                none
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        index = 6'd0;
        none  = 1'b1;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                index = 6'(i);
                none  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/gpio_in_ext.sv
// rtl/gpio_in_ext.sv - captured multi-channel input port with blocking bus reads (optional irq: GPIO_IN_IRQ_EN)
module gpio_in_ext #(
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    input  logic                  read,
    input  logic                  write,
    output logic                  ready_r,
    output logic                  ready_w,
    input  logic [CHANNELS-1:0]   port_write,
    input  logic [CHANNELS*8-1:0] port_in
`ifdef GPIO_IN_IRQ_EN
    ,
    output logic                  irq
`endif
);

    import gpio_pkg::*;

    localparam int CTRL_ADDR   = CHANNELS;
    localparam int STATUS_ADDR = CHANNELS + 1;

    logic [7:0]          data [CHANNELS];
    logic [CHANNELS-1:0] pending;
    logic                ctrl_block;
    logic                ctrl_tmo;
    logic                irq_en_bit;
    rd_state_t           state;
    rd_state_t           state_next;
    logic [ADDR_W-1:0]   rd_addr;
    logic [15:0]         counter;
    logic [5:0]          prio_idx;
    logic                prio_none;
    logic [7:0]          status_val;
    logic [7:0]          ctrl_val;
    logic [7:0]          rd_data;
    logic                addr_is_chan;
    logic                addr_ready;
    logic                rd_is_chan;
    logic                pw_hit;
    logic                accept;
    logic                rd_done;
    logic                tmo_hit;

    gpio_prio_enc #(.CHANNELS(CHANNELS)) u_prio (
        .pending (pending),
        .index   (prio_idx),
        .none    (prio_none)
    );

`ifdef GPIO_IN_IRQ_EN
    logic ctrl_irq_en;
    assign irq_en_bit = ctrl_irq_en;

    // Interrupt is a registered view of "anything pending" gated by IRQ_EN.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (|pending) & ctrl_irq_en;
        end
    end
`else
    assign irq_en_bit = 1'b0;
`endif

    assign status_val = {prio_none, 1'b0, prio_idx};
    assign ctrl_val   = {ctrl_tmo, 5'b00000, irq_en_bit, ctrl_block};

    // Decode the live bus address (for read acceptance) and the latched read address (for the response).
    always_comb begin
        addr_is_chan = 1'b0;
        addr_ready   = 1'b0;
        rd_is_chan   = 1'b0;
        pw_hit       = 1'b0;
        rd_data      = 8'h00;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(address) == i) begin
                addr_is_chan = 1'b1;
                addr_ready   = pending[i] | port_write[i];
            end
            if (int'(rd_addr) == i) begin
                rd_is_chan = 1'b1;
                pw_hit     = port_write[i];
                rd_data    = data[i];
            end
        end
        if (int'(rd_addr) == CTRL_ADDR) begin
            rd_data = ctrl_val;
        end else if (int'(rd_addr) == STATUS_ADDR) begin
            rd_data = status_val;
        end
    end

    // Read FSM next state; a read is not re-accepted while the previous ready_r is still visible.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        rd_done    = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (read && !ready_r) begin
                    accept = 1'b1;
                    if (!ctrl_block || !addr_is_chan || addr_ready) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!read) begin
                    state_next = ST_IDLE;
                end else if (pw_hit) begin
                    state_next = ST_RESP;
                end else if (counter <= 16'd1) begin
                    state_next = ST_RESP;
                    tmo_hit    = 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
                rd_done    = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Channel data, pending flags, CTRL, timeout counter and bus response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                data[i] <= 8'h00;
            end
            pending    <= '0;
            ctrl_block <= 1'b0;
            ctrl_tmo   <= 1'b0;
`ifdef GPIO_IN_IRQ_EN
            ctrl_irq_en <= 1'b0;
`endif
            counter    <= 16'd0;
            rd_addr    <= '0;
            data_out   <= 8'h00;
            ready_r    <= 1'b0;
            ready_w    <= 1'b0;
        end else begin
            ready_w <= write;
            ready_r <= rd_done;
            if (rd_done) begin
                data_out <= rd_data;
            end
            if (accept) begin
                rd_addr <= address;
                counter <= 16'(TIMEOUT);
            end else if (state == ST_WAIT && counter != 16'd0) begin
                counter <= counter - 16'd1;
            end
            // Port capture beats both a bus write and a read-completion clear on the same channel.
            for (int i = 0; i < CHANNELS; i++) begin
                if (port_write[i]) begin
                    data[i]    <= port_in[8*i +: 8];
                    pending[i] <= 1'b1;
                end else begin
                    if (write && int'(address) == i) begin
                        data[i] <= data_in;
                    end
                    if (rd_done && rd_is_chan && int'(rd_addr) == i) begin
                        pending[i] <= 1'b0;
                    end
                end
            end
            // A CTRL write with bit7 set only clears the timeout flag; otherwise it updates the control bits.
            if (write && int'(address) == CTRL_ADDR) begin
                if (data_in[CTRL_TIMEOUT_FLAG]) begin
                    ctrl_tmo <= 1'b0;
                end else begin
                    ctrl_block <= data_in[CTRL_BLOCK];
`ifdef GPIO_IN_IRQ_EN
                    ctrl_irq_en <= data_in[CTRL_IRQ_EN];
`endif
                end
            end
            if (tmo_hit) begin
                ctrl_tmo <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpio_in_ext.sv
// tb/tb_gpio_in_ext.sv - randomized self-checking bench for gpio_in_ext against a register-level model
module tb_gpio_in_ext;

    localparam int CH  = 4;
    localparam int AW  = 3;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [AW-1:0]   address = '0;
    logic [7:0]      data_in = 8'h00;
    logic [7:0]      data_out;
    logic            read = 1'b0;
    logic            write = 1'b0;
    logic            ready_r;
    logic            ready_w;
    logic [CH-1:0]   port_write = '0;
    logic [CH*8-1:0] port_in = '0;
`ifdef GPIO_IN_IRQ_EN
    logic            irq;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]    m_data [CH];
    logic [CH-1:0] m_pending;
    logic          m_block;
    logic          m_irq_en;
    logic          m_tmo;

    gpio_in_ext #(.CHANNELS(CH), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .ready_r    (ready_r),
        .ready_w    (ready_w),
        .port_write (port_write),
        .port_in    (port_in)
`ifdef GPIO_IN_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) m_data[i] = 8'h00;
        m_pending = '0;
        m_block   = 1'b0;
        m_irq_en  = 1'b0;
        m_tmo     = 1'b0;
    endtask

    function automatic logic [7:0] model_reg(int a);
        if (a < CH) return m_data[a];
        if (a == CH) return {m_tmo, 5'b00000, m_irq_en, m_block};
        if (a == CH + 1) begin
            for (int i = 0; i < CH; i++) if (m_pending[i]) return 8'(i);
            return 8'h80;
        end
        return 8'h00;
    endfunction

    // Expected result of a read with no port activity while it waits.
    task automatic model_read(input int a, output logic [7:0] exp_d, output int exp_lat);
        logic blocking;
        blocking = m_block && (a < CH) && !m_pending[a];
        exp_d    = model_reg(a);
        exp_lat  = blocking ? TMO + 2 : 2;
        if (blocking) m_tmo = 1'b1;
        if (a < CH) m_pending[a] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        read  = 1'b0;
        write = 1'b0;
        port_write = '0;
        step();
        step();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_port_write(input logic [CH-1:0] mask, input logic [CH*8-1:0] vals);
        port_in    = vals;
        port_write = mask;
        for (int i = 0; i < CH; i++) begin
            if (mask[i]) begin
                m_data[i]    = vals[8*i +: 8];
                m_pending[i] = 1'b1;
            end
        end
        step();
        port_write = '0;
    endtask

    task automatic bus_write(input int a, input logic [7:0] d, output logic rw);
        address = AW'(a);
        data_in = d;
        write   = 1'b1;
        step();
        rw    = ready_w;
        write = 1'b0;
        if (a < CH) begin
            m_data[a] = d;
        end else if (a == CH) begin
            if (d[7]) begin
                m_tmo = 1'b0;
            end else begin
                m_block = d[0];
`ifdef GPIO_IN_IRQ_EN
                m_irq_en = d[1];
`endif
            end
        end
    endtask

    // Holds read until ready_r, then leaves one idle cycle; lat is the edge count, -1 on no response.
    task automatic bus_read(input int a, output logic [7:0] d, output int lat);
        logic got;
        address = AW'(a);
        read    = 1'b1;
        lat     = 0;
        got     = 1'b0;
        while (!got && lat < 100) begin
            step();
            lat++;
            if (ready_r) got = 1'b1;
        end
        d    = data_out;
        read = 1'b0;
        if (!got) lat = -1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (data_out !== 8'h00 || ready_r !== 1'b0 || ready_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data_out=%h ready_r=%b ready_w=%b, required 00/0/0", data_out, ready_r, ready_w);
        end
`ifdef GPIO_IN_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
`endif
    endtask

    task automatic test_nonblocking();
        logic [7:0] d, e;
        int lat, el;
        do_reset();
        do_port_write(4'b0100, 32'h00A5_0000);
        model_read(CH + 1, e, el);
        bus_read(CH + 1, d, lat);
        checks++;
        if (d !== 8'h02 || d !== e) begin errors++; $display("FAIL status_before: got %h required 02 (model %h)", d, e); end
        model_read(2, e, el);
        bus_read(2, d, lat);
        checks++;
        if (d !== 8'hA5 || d !== e) begin errors++; $display("FAIL nb_read_data: got %h required a5", d); end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL nb_read_latency: got %0d required 2", lat); end
        model_read(CH + 1, e, el);
        bus_read(CH + 1, d, lat);
        checks++;
        if (d !== 8'h80 || d !== e) begin errors++; $display("FAIL status_after: got %h required 80", d); end
    endtask

    task automatic test_blocking_port_write();
        logic [7:0] d;
        logic rw;
        int lat;
        do_reset();
        bus_write(CH, 8'h01, rw);
        fork
            bus_read(1, d, lat);
            begin
                repeat (10) step();
                do_port_write(4'b0010, 32'h0000_3C00);
            end
        join
        m_pending[1] = 1'b0;
        checks++;
        if (d !== 8'h3C) begin errors++; $display("FAIL block_pw_data: got %h required 3c", d); end
        checks++;
        if (lat != 12) begin errors++; $display("FAIL block_pw_latency: got %0d required 12", lat); end
    endtask

    task automatic test_timeout();
        logic [7:0] d, e;
        logic rw;
        int lat, el;
        do_reset();
        bus_write(0, 8'h5A, rw);
        bus_write(CH, 8'h01, rw);
        model_read(0, e, el);
        bus_read(0, d, lat);
        checks++;
        if (d !== 8'h5A || d !== e) begin errors++; $display("FAIL timeout_data: got %h required 5a", d); end
        checks++;
        if (lat != TMO + 2 || lat != el) begin errors++; $display("FAIL timeout_latency: got %0d required %0d", lat, TMO + 2); end
        model_read(CH, e, el);
        bus_read(CH, d, lat);
        checks++;
        if (d !== 8'h81 || d !== e) begin errors++; $display("FAIL timeout_flag: got %h required 81", d); end
        bus_write(CH, 8'h80, rw);
        model_read(CH, e, el);
        bus_read(CH, d, lat);
        checks++;
        if (d !== 8'h01 || d !== e) begin errors++; $display("FAIL flag_clear: got %h required 01", d); end
    endtask

    task automatic test_collision();
        logic [7:0] d, e;
        int lat, el;
        do_reset();
        address    = AW'(3);
        data_in    = 8'h11;
        write      = 1'b1;
        port_in    = 32'h2200_0000;
        port_write = 4'b1000;
        step();
        write      = 1'b0;
        port_write = '0;
        m_data[3]  = 8'h22;
        m_pending[3] = 1'b1;
        checks++;
        if (ready_w !== 1'b1) begin errors++; $display("FAIL collision_ready_w: got %b required 1", ready_w); end
        model_read(CH + 1, e, el);
        bus_read(CH + 1, d, lat);
        checks++;
        if (d !== 8'h03 || d !== e) begin errors++; $display("FAIL collision_pending: status %h required 03", d); end
        model_read(3, e, el);
        bus_read(3, d, lat);
        checks++;
        if (d !== 8'h22 || d !== e) begin errors++; $display("FAIL collision_data: got %h required 22", d); end
    endtask

    task automatic test_reset_in_wait();
        logic [7:0] d, e;
        logic rw;
        int lat, el;
        logic saw_ready;
        do_reset();
        do_port_write(4'b1111, 32'h4433_2211);
        bus_write(CH, 8'h01, rw);
        model_read(2, e, el);
        bus_read(2, d, lat);
        address   = AW'(2);
        read      = 1'b1;
        saw_ready = 1'b0;
        repeat (5) begin
            step();
            if (ready_r) saw_ready = 1'b1;
        end
        reset = 1'b1;
        read  = 1'b0;
        step();
        if (ready_r) saw_ready = 1'b1;
        reset = 1'b0;
        step();
        if (ready_r) saw_ready = 1'b1;
        model_reset();
        checks++;
        if (saw_ready !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_in_wait: ready_r seen=%b data_out=%h, required 0/00", saw_ready, data_out);
        end
        for (int a = 0; a < (1 << AW); a++) begin
            model_read(a, e, el);
            bus_read(a, d, lat);
            checks++;
            if (d !== e || lat != el) begin
                errors++;
                $display("FAIL post_reset_read a=%0d: got %h lat %0d required %h lat %0d", a, d, lat, e, el);
            end
        end
    endtask

    task automatic test_irq();
        logic [7:0] d, e;
        logic rw;
        int lat, el;
        do_reset();
        bus_write(CH, 8'h02, rw);
        model_read(CH, e, el);
        bus_read(CH, d, lat);
        checks++;
        if (d !== e) begin errors++; $display("FAIL irq_en_ctrl: got %h required %h", d, e); end
`ifdef GPIO_IN_IRQ_EN
        do_port_write(4'b0001, 32'h0000_0077);
        step();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b required 1", irq); end
        model_read(0, e, el);
        bus_read(0, d, lat);
        step();
        checks++;
        if (irq !== 1'b0 || d !== 8'h77) begin errors++; $display("FAIL irq_clear: irq %b data %h required 0/77", irq, d); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] d, e;
        logic rw;
        int lat, el, a;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0: do_port_write(CH'($urandom_range(1, (1 << CH) - 1)), $urandom);
                1: begin
                    a = $urandom_range(0, (1 << AW) - 1);
                    bus_write(a, 8'($urandom), rw);
                    checks++;
                    if (rw !== 1'b1) begin errors++; $display("FAIL rand_ready_w a=%0d: got %b required 1", a, rw); end
                end
                default: begin
                    a = $urandom_range(0, (1 << AW) - 1);
                    model_read(a, e, el);
                    bus_read(a, d, lat);
                    checks++;
                    if (d !== e || lat != el) begin
                        errors++;
                        $display("FAIL rand_read a=%0d: got %h lat %0d required %h lat %0d", a, d, lat, e, el);
                    end
                end
            endcase
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_nonblocking();
        test_blocking_port_write();
        test_timeout();
        test_collision();
        test_reset_in_wait();
        test_irq();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_in_ext.md
GPIO_IN_EXT -- requirements
Module: gpio_in_ext

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning number of 8-bit input channels (1..64).
REQ-002 SHALL have parameter ADDR_W, default 3, meaning address width; 2**ADDR_W >= CHANNELS+2.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning blocking-read timeout in clk cycles (1..65535).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  ADDR_W  register select.
REQ-007 data_in  input  8  bus write data.
REQ-008 data_out  output  8  registered bus read data.
REQ-009 read  input  1  read request, held until ready_r.
REQ-010 write  input  1  write request, single cycle.
REQ-011 ready_r  output  1  one-cycle read-complete pulse.
REQ-012 ready_w  output  1  one-cycle write-complete pulse.
REQ-013 port_write  input  CHANNELS  per-channel capture strobe.
REQ-014 port_in  input  CHANNELS*8  channel i on bits [8i+7:8i].

Function
REQ-015 Address map SHALL be: 0..CHANNELS-1 channel data (R/W); CHANNELS = CTRL (R/W); CHANNELS+1 = STATUS (RO); others read 8'h00, writes ignored.
REQ-016 CTRL SHALL be: bit0 BLOCK (blocking reads), bit1 IRQ_EN, bit7 TIMEOUT_FLAG (sticky, cleared by writing 1), others 0.
REQ-017 port_write[i] high SHALL load port_in channel i into data[i] and set pending[i] next edge.
REQ-018 Bus write to channel i SHALL load data_in and leave pending[i] unchanged; if port_write[i] same cycle, port value SHALL win.
REQ-019 STATUS SHALL return index of lowest-numbered pending channel in bits[5:0], bit7=1 when none pending.
REQ-020 Read FSM SHALL have states IDLE, WAIT, RESP.
REQ-021 IDLE + read: non-blocking path (BLOCK=0, non-channel address, or pending set) -> RESP; else -> WAIT with timeout counter loaded with TIMEOUT.
REQ-022 RESP SHALL drive data_out with selected register and assert ready_r for exactly one cycle, then return to IDLE; non-blocking read latency = 2 edges from read.
REQ-023 WAIT SHALL decrement counter each cycle; on port_write of addressed channel -> RESP returning the new value; on counter reaching 0 -> RESP returning current data, set TIMEOUT_FLAG.
REQ-024 Completed read of channel i SHALL clear pending[i]; a coincident port_write[i] SHALL leave pending[i] set.
REQ-025 Read SHALL not restart while ready_r is high; read deasserting in WAIT SHALL abort to IDLE without ready_r.
REQ-026 ready_w SHALL pulse one cycle after each write, regardless of FSM state; writes SHALL not disturb a pending read.
REQ-027 data_out SHALL hold last read value between reads.

Reset
REQ-028 Reset SHALL clear all data, pending, CTRL, counter, data_out, ready_r, ready_w to 0 and FSM to IDLE, including mid-WAIT (no ready_r issued).

Configuration
REQ-029 With GPIO_IN_IRQ_EN defined, output irq (1 bit) SHALL be registered OR of pending bits AND IRQ_EN.
REQ-030 Without GPIO_IN_IRQ_EN, irq port and IRQ_EN storage SHALL be absent; CTRL bit1 reads 0.

Structure
REQ-031 Shared package gpio_pkg SHALL hold read-FSM state encoding and CTRL bit position constants.
REQ-032 Lowest-pending priority encoder SHALL be sub-module gpio_prio_enc (parameter CHANNELS).

Verification
REQ-033 port_in ch2=8'hA5, port_write=4'b0100; read addr 2 -> ready_r 2 edges later, data_out=8'hA5, STATUS before read=8'h02, after=8'h80.
REQ-034 CTRL=8'h01, read addr 1 with no pending; port_write[1] with 8'h3C after 10 cycles -> ready_r one edge after, data_out=8'h3C.
REQ-035 TIMEOUT=16, blocking read of idle ch0 -> ready_r after 17 cycles, data_out=old value, CTRL reads 8'h81; write 8'h80 to CTRL -> reads 8'h01.
REQ-036 Same-cycle bus write 8'h11 and port_write 8'h22 on ch3 -> data[3]=8'h22, pending[3]=1.
REQ-037 Reset asserted in WAIT -> no ready_r, all registers 0, next read completes normally.
REQ-038 GPIO_IN_IRQ_EN build, IRQ_EN=1, port_write[0] -> irq=1; read ch0 -> irq=0.
